// File: rtl/regfile_sb.sv
// Multi-port register file with EX/MEM/WB bypass and a pending-write scoreboard.
// Optional `REGFILE_BYPASS_EN` enables EX/MEM forwarding; otherwise any EX/MEM match stalls.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int REG_NUM  = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_we_i,
    input  logic [ADDR_W-1:0]            wb_waddr_i,
    input  logic [DATA_W-1:0]            wb_wdata_i,
    input  logic                         mem_we_i,
    input  logic [ADDR_W-1:0]            mem_waddr_i,
    input  logic [DATA_W-1:0]            mem_wdata_i,
    input  logic                         mem_is_load_i,
    input  logic                         mem_ld_done_i,
    input  logic                         ex_we_i,
    input  logic [ADDR_W-1:0]            ex_waddr_i,
    input  logic [DATA_W-1:0]            ex_wdata_i,
    input  logic                         ex_is_load_i,
    input  logic [RD_PORTS-1:0]          re_i,
    input  logic [RD_PORTS*ADDR_W-1:0]   raddr_i,
    input  logic                         iss_valid_i,
    input  logic                         iss_we_i,
    input  logic [ADDR_W-1:0]            iss_rd_i,
    output logic [RD_PORTS*DATA_W-1:0]   rdata_o,
    output logic                         stallreq_o,
    output logic [31:0]                  stall_cnt_o
);

    logic [DATA_W-1:0]   regs [REG_NUM];
    logic [1:0]          pend [REG_NUM];
    logic [RD_PORTS-1:0] port_stall;
    logic [REG_NUM-1:0]  inc;
    logic [REG_NUM-1:0]  dec;
    logic                iss_full;
    logic                ex_wait;
    logic                mem_wait;

    // Whether a matching EX/MEM producer must stall instead of forwarding
`ifdef REGFILE_BYPASS_EN
    assign ex_wait  = ex_is_load_i;
    assign mem_wait = mem_is_load_i && !mem_ld_done_i;
`else
    assign ex_wait  = 1'b1;
    assign mem_wait = 1'b1;
`endif

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              stl;

        assign addr = raddr_i[p*ADDR_W +: ADDR_W];

        always_comb begin
            data = '0;
            stl  = 1'b0;
            if (re_i[p] && addr != '0) begin
                if (ex_we_i && addr == ex_waddr_i) begin
                    if (ex_wait) stl = 1'b1;
                    else         data = ex_wdata_i;
                end else if (mem_we_i && addr == mem_waddr_i) begin
                    if (mem_wait) stl = 1'b1;
                    else          data = mem_wdata_i;
                end else if (wb_we_i && addr == wb_waddr_i) begin
                    data = wb_wdata_i;
                end else if (pend[addr] != 2'd0) begin
                    stl = 1'b1;
                end else begin
                    data = regs[addr];
                end
            end
        end

        assign rdata_o[p*DATA_W +: DATA_W] = rst ? data : '0;
        assign port_stall[p] = stl;
    end

    assign iss_full = iss_valid_i && iss_we_i && iss_rd_i != '0
                      && pend[iss_rd_i] == 2'd3;
    assign stallreq_o = rst && ((|port_stall) || iss_full);

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            inc[r] = iss_valid_i && iss_we_i && iss_rd_i == ADDR_W'(r)
                     && !stallreq_o;
            dec[r] = wb_we_i && wb_waddr_i == ADDR_W'(r);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < REG_NUM; r++) regs[r] <= '0;
        end else if (wb_we_i && wb_waddr_i != '0) begin
            regs[wb_waddr_i] <= wb_wdata_i;
        end
    end

    // Simultaneous issue and retire to the same register cancel out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < REG_NUM; r++) pend[r] <= 2'd0;
        end else begin
            for (int r = 0; r < REG_NUM; r++) begin
                if (inc[r] && !dec[r])
                    pend[r] <= pend[r] + 2'd1;
                else if (dec[r] && !inc[r] && pend[r] != 2'd0)
                    pend[r] <= pend[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt_o <= '0;
        else if (stallreq_o && stall_cnt_o != 32'hFFFF_FFFF)
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed hazard scenarios plus random traffic.
// Expected responses come from a producer-list model of the register file.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RP = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          wb_we, mem_we, mem_is_load, mem_ld_done;
    logic          ex_we, ex_is_load, iss_valid, iss_we;
    logic [AW-1:0] wb_waddr, mem_waddr, ex_waddr, iss_rd;
    logic [DW-1:0] wb_wdata, mem_wdata, ex_wdata;
    logic [RP-1:0] re;
    logic [RP*AW-1:0] raddr;
    logic [RP*DW-1:0] rdata;
    logic          stallreq;
    logic [31:0]   stall_cnt;

    regfile_sb #(.DATA_W(DW), .REG_NUM(32), .ADDR_W(AW), .RD_PORTS(RP)) dut (
        .clk(clk), .rst(rst),
        .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
        .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
        .mem_is_load_i(mem_is_load), .mem_ld_done_i(mem_ld_done),
        .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .ex_is_load_i(ex_is_load), .re_i(re), .raddr_i(raddr),
        .iss_valid_i(iss_valid), .iss_we_i(iss_we), .iss_rd_i(iss_rd),
        .rdata_o(rdata), .stallreq_o(stallreq), .stall_cnt_o(stall_cnt)
    );

    typedef struct {
        logic [RP*DW-1:0] rdata;
        logic             stall;
        logic [31:0]      cnt;
        int               id;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;
    int cyc_id = 0;

    logic [DW-1:0] m_regs [32];
    int            m_pend [32];
    logic [31:0]   m_cnt;

    function automatic void m_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        m_cnt = '0;
    endfunction

    // Youngest producer of the address decides; then scoreboard; then array
    function automatic void m_port(input int p, output logic [DW-1:0] d,
                                   output bit s);
        logic [AW-1:0] a;
        bit            hit [3];
        bit            vis [3];
        logic [DW-1:0] val [3];
        a = raddr[p*AW +: AW];
        d = '0;
        s = 1'b0;
        if (!re[p] || a == 0) return;
        hit[0] = ex_we && a == ex_waddr;
        vis[0] = BYP && !ex_is_load;
        val[0] = ex_wdata;
        hit[1] = mem_we && a == mem_waddr;
        vis[1] = BYP && (!mem_is_load || mem_ld_done);
        val[1] = mem_wdata;
        hit[2] = wb_we && a == wb_waddr;
        vis[2] = 1'b1;
        val[2] = wb_wdata;
        for (int k = 0; k < 3; k++) begin
            if (hit[k]) begin
                if (vis[k]) d = val[k];
                else        s = 1'b1;
                return;
            end
        end
        if (m_pend[a] != 0) s = 1'b1;
        else                d = m_regs[a];
    endfunction

    task automatic evaluate();
        exp_t e;
        logic [DW-1:0] d;
        bit s;
        int n;
        e.id = cyc_id++;
        e.rdata = '0;
        e.stall = 1'b0;
        if (!rst) begin
            m_reset();
            e.cnt = '0;
            sbq.push_back(e);
            return;
        end
        for (int p = 0; p < RP; p++) begin
            m_port(p, d, s);
            e.rdata[p*DW +: DW] = d;
            e.stall |= s;
        end
        if (iss_valid && iss_we && iss_rd != 0 && m_pend[iss_rd] == 3)
            e.stall = 1'b1;
        e.cnt = m_cnt;
        sbq.push_back(e);
        if (wb_we && wb_waddr != 0) m_regs[wb_waddr] = wb_wdata;
        for (int r = 1; r < 32; r++) begin
            n = m_pend[r];
            if (iss_valid && iss_we && iss_rd == r && !e.stall) n++;
            if (wb_we && wb_waddr == r) n--;
            m_pend[r] = (n < 0) ? 0 : n;
        end
        if (e.stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    endtask

    task automatic idle();
        wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        mem_we = 0; mem_waddr = 0; mem_wdata = 0;
        mem_is_load = 0; mem_ld_done = 0;
        ex_we = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
        re = 0; raddr = 0;
        iss_valid = 0; iss_we = 0; iss_rd = 0;
    endtask

    task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        re = 2'b11;
        raddr = {a1, a0};
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        iss_valid = 1; iss_we = 1; iss_rd = rd;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] v);
        wb_we = 1; wb_waddr = a; wb_wdata = v;
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        idle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rdata cyc=%0d got=%h exp=%h",
                             e.id, rdata, e.rdata);
                end
                checks++;
                if (stallreq !== e.stall) begin
                    errors++;
                    $display("FAIL stallreq cyc=%0d got=%b exp=%b",
                             e.id, stallreq, e.stall);
                end
                checks++;
                if (stall_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d",
                             e.id, stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        rst = 1'b0;
        idle();
        m_reset();
        // Reset held: outputs stay zero even with a live EX producer
        repeat (3) begin
            cyc_begin();
            ex_we = 1; ex_waddr = 5; ex_wdata = 32'h1234; ex_is_load = 1;
            rd2(5, 5);
            evaluate();
        end
        cyc_begin(); rst = 1'b1;
        wb(0, 32'hDEAD_BEEF); rd2(0, 5); evaluate();
        cyc_begin(); rd2(0, 5); evaluate();

        // Bypass priority
        cyc_begin();
        ex_we = 1; ex_waddr = 3; ex_wdata = 32'h11;
        mem_we = 1; mem_waddr = 3; mem_wdata = 32'h22;
        wb(3, 32'h33); rd2(3, 3); evaluate();
        cyc_begin(); rd2(3, 3); evaluate();

        // Load-use hazard
        cyc_begin();
        ex_we = 1; ex_waddr = 7; ex_is_load = 1; ex_wdata = 32'hBAD;
        rd2(7, 0); evaluate();
        for (int i = 0; i < 4; i++) begin
            cyc_begin();
            mem_we = 1; mem_waddr = 7; mem_is_load = 1;
            mem_ld_done = (i == 3);
            mem_wdata = (i == 3) ? 32'hCAFE : 32'h0;
            rd2(7, 0); evaluate();
        end

        // Scoreboard gap
        cyc_begin(); issue(9); evaluate();
        repeat (2) begin cyc_begin(); rd2(9, 1); evaluate(); end
        cyc_begin(); wb(9, 32'h55); rd2(9, 1); evaluate();
        cyc_begin(); rd2(9, 9); evaluate();

        // Pending counter saturation and cancelling events
        repeat (3) begin cyc_begin(); issue(4); evaluate(); end
        cyc_begin(); issue(4); evaluate();
        cyc_begin(); wb(4, 32'h44); evaluate();
        cyc_begin(); issue(4); wb(4, 32'h45); evaluate();
        cyc_begin(); issue(4); evaluate();
        cyc_begin(); issue(4); evaluate();
        cyc_begin(); wb(4, 32'h46); evaluate();
        guard = 0;
        while (m_cnt < 10 && guard < 20) begin
            cyc_begin(); rd2(4, 4); evaluate();
            guard++;
        end

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2 rst = 1'b0;
        cyc_begin(); rd2(4, 4); issue(4); evaluate();
        cyc_begin(); rst = 1'b1; rd2(4, 4); evaluate();

        // Random traffic over a small register window to force collisions
        for (int i = 0; i < 1500; i++) begin
            cyc_begin();
            wb_we = $urandom_range(0, 1) == 1;
            wb_waddr = AW'($urandom_range(0, 7));
            wb_wdata = $urandom;
            mem_we = $urandom_range(0, 2) == 0;
            mem_waddr = AW'($urandom_range(0, 7));
            mem_wdata = $urandom;
            mem_is_load = $urandom_range(0, 1) == 1;
            mem_ld_done = $urandom_range(0, 1) == 1;
            ex_we = $urandom_range(0, 2) == 0;
            ex_waddr = AW'($urandom_range(0, 7));
            ex_wdata = $urandom;
            ex_is_load = $urandom_range(0, 3) == 0;
            re = RP'($urandom_range(0, 3));
            raddr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            iss_valid = $urandom_range(0, 1) == 1;
            iss_we = $urandom_range(0, 3) != 0;
            iss_rd = AW'($urandom_range(0, 7));
            evaluate();
        end

        cyc_begin(); evaluate();
        guard = 0;
        while (sbq.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #5;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port register file for the RV32I pipeline.
- Combines operand bypass from EX/MEM/WB with a per-register pending-write scoreboard, so it stays correct when MEM takes multiple cycles or bubbles separate a producer from its consumer.
- Sits between ID (read/issue), EX/MEM (bypass sources) and MEM_WB (write port).
- Drives the single stall request into stallctrl and keeps a stall-cycle performance counter.

Parameters:
- DATA_W, 32, register width.
- REG_NUM, 32, number of architectural registers; register 0 is hard-wired to zero.
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= REG_NUM.
- RD_PORTS, 2, number of read ports.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- wb_we_i  in  1  WB write enable.
- wb_waddr_i  in  ADDR_W  WB destination.
- wb_wdata_i  in  DATA_W  WB data.
- mem_we_i  in  1  MEM-stage instruction writes a register.
- mem_waddr_i  in  ADDR_W  MEM destination.
- mem_wdata_i  in  DATA_W  MEM result (ALU value, or load data once mem_ld_done_i is high).
- mem_is_load_i  in  1  MEM instruction is a load.
- mem_ld_done_i  in  1  load data valid on mem_wdata_i this cycle.
- ex_we_i  in  1  EX writes a register.
- ex_waddr_i  in  ADDR_W  EX destination.
- ex_wdata_i  in  DATA_W  EX ALU result.
- ex_is_load_i  in  1  EX instruction is a load.
- re_i  in  RD_PORTS  per-port read enable.
- raddr_i  in  RD_PORTS*ADDR_W  packed read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- iss_valid_i  in  1  ID holds a valid instruction.
- iss_we_i  in  1  that instruction writes rd.
- iss_rd_i  in  ADDR_W  its rd.
- rdata_o  out  RD_PORTS*DATA_W  packed read data; combinational.
- stallreq_o  out  1  stall request to stallctrl; combinational.
- stall_cnt_o  out  32  saturating count of cycles in which stallreq_o was high.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers, pending counters and stall_cnt_o clear to 0.
  - rdata_o=0, stallreq_o=0 while reset is held.
- Write: at posedge, if wb_we_i && wb_waddr_i!=0, then regs[wb_waddr_i] <= wb_wdata_i.
- Pending counter pend[r], 2 bits, for each r != 0:
  - inc = iss_valid_i && iss_we_i && iss_rd_i==r && iss_rd_i!=0 && !stallreq_o.
  - dec = wb_we_i && wb_waddr_i==r.
  - inc && dec: unchanged. inc only: +1. dec only: -1. Decrement at 0 holds at 0 and is not an error.
  - pend[0] is always 0.
- Read port p, evaluated per port in priority order; each condition is checked only if all earlier ones are false:
  - !re_i[p]: data 0, no stall.
  - addr==0: data 0, no stall.
  - ex_we_i && addr==ex_waddr_i: if ex_is_load_i, stall; else data = ex_wdata_i.
  - mem_we_i && addr==mem_waddr_i: if mem_is_load_i && !mem_ld_done_i, stall; else data = mem_wdata_i.
  - wb_we_i && addr==wb_waddr_i: data = wb_wdata_i (write-through).
  - pend[addr]!=0: stall (writer in flight with no visible data).
  - otherwise: data = regs[addr].
- Stalled ports drive data 0.
- Issue-full: iss_valid_i && iss_we_i && iss_rd_i!=0 && pend[iss_rd_i]==3 raises a stall, so no counter ever overflows.
- stallreq_o = OR of all per-port stalls OR issue-full.
- Stall counter: stall_cnt_o increments each cycle stallreq_o=1 and saturates at 0xFFFFFFFF.
- Reset mid-stall: all pending state is lost. The pipeline is flushed by the same reset.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - EX and MEM bypass exactly as above.
- REGFILE_BYPASS_EN undefined:
  - any EX or MEM address match with its we asserted stalls, regardless of load status.
  - WB write-through and the scoreboard are unchanged.
  - Lower-area, slower build used for timing experiments.

Test Plan:
- Reset and zero register:
  - Stimulus: hold rst=0, then release; write x0=0xDEADBEEF via WB; read x0 and x5.
  - Required: both read 0, stallreq_o=0, stall_cnt_o=0.
- Bypass priority:
  - Stimulus: ex(x3=0x11), mem(x3=0x22), wb(x3=0x33), all non-load, both ports read x3.
  - Required: both ports return 0x11; with the macro undefined, stallreq_o=1.
- Load-use hazard:
  - Stimulus: ex_is_load_i for x7 while reading x7; next cycle it is in MEM with mem_ld_done_i=0 for 3 cycles, then 1 with data 0xCAFE.
  - Required: stallreq_o=1 for 4 cycles, then rdata=0xCAFE; stall_cnt_o=4.
- Scoreboard gap:
  - Stimulus: issue writer to x9 (pend=1), insert bubbles so x9 is in no stage, read x9.
  - Required: stall until WB writes x9=0x55; same cycle rdata=0x55; next cycle pend[9]=0 and the read comes from the array.
- Counter saturation and simultaneous events:
  - Stimulus: issue 3 writers to x4 with no WB, attempt a 4th.
  - Required: the 4th raises stallreq_o; a WB to x4 in the same cycle as an issue leaves pend[4] unchanged.
- Async reset mid-operation:
  - Stimulus: pend[4]=2, stall_cnt_o=10; drop rst between clock edges.
  - Required: outputs clear immediately; after release, reading x4 gives 0 with no stall.
